// File: rtl/dig8_wr_arbiter.sv
// dig8_wr_arbiter
// Arbitrates two write requesters onto the 8-digit seven-segment display
// write port. A 32-bit shadow of the displayed value (one nibble per digit)
// is kept. Each granted request is merged into it under a per-digit mask.
// The full merged word is then written to the display at a fixed address.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   a_req/a_mask/a_data  requester A (CPU store path); a_gnt one-cycle grant
//   b_req/b_mask/b_data  requester B (hardware status); b_gnt one-cycle grant
//   wen, addr, wdata     display write port (one-cycle wen, addr constant)
//   cur_val              current shadow value for readback
//
// State   | meaning
// --------+------------------------------------------------------------
// INIT    | leaving reset; next edge writes RESET_VAL to the display
// IDLE    | sampling requests; a win merges, grants and (maybe) writes
// WRITE   | grant/write cycle in progress; requests are not sampled
module dig8_wr_arbiter #(
  parameter logic [11:0] DISP_ADDR = 12'h000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req,
  input  logic [7:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        a_gnt,
  input  logic        b_req,
  input  logic [7:0]  b_mask,
  input  logic [31:0] b_data,
  output logic        b_gnt,
  output logic        wen,
  output logic [11:0] addr,
  output logic [31:0] wdata,
  output logic [31:0] cur_val
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] shadow;
  // High when B won the most recent contended sample, so A is favoured next.
  logic        last_winner_b;

  logic        pick_a;
  logic        pick_b;
  logic        contended;
  logic [7:0]  win_mask;
  logic [31:0] win_data;
  logic [31:0] win_m32;
  logic [31:0] merged;

  // Round-robin only matters when both request on the same edge.
  always_comb begin
    contended = a_req && b_req;
    pick_a    = 1'b0;
    pick_b    = 1'b0;
    if (contended) begin
      pick_a = last_winner_b;
      pick_b = !last_winner_b;
    end else begin
      pick_a = a_req;
      pick_b = b_req;
    end
  end

  always_comb begin
    win_mask = pick_b ? b_mask : a_mask;
    win_data = pick_b ? b_data : a_data;
  end

  // Each mask bit covers one digit nibble.
  always_comb begin
    win_m32 = '0;
    for (int i = 0; i < 8; i++) begin
      win_m32[4*i +: 4] = {4{win_mask[i]}};
    end
    merged = (shadow & ~win_m32) | (win_data & win_m32);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_INIT;
      shadow        <= RESET_VAL;
      wen           <= 1'b0;
      a_gnt         <= 1'b0;
      b_gnt         <= 1'b0;
      wdata         <= RESET_VAL;
      last_winner_b <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          wen   <= 1'b1;
          wdata <= shadow;
          a_gnt <= 1'b0;
          b_gnt <= 1'b0;
          state <= ST_IDLE;
        end

        ST_IDLE: begin
          wen   <= 1'b0;
          a_gnt <= 1'b0;
          b_gnt <= 1'b0;
          if (pick_a || pick_b) begin
            a_gnt  <= pick_a;
            b_gnt  <= pick_b;
            shadow <= merged;
            // A zero-mask request still takes its turn but writes nothing.
            if (|win_mask) begin
              wen   <= 1'b1;
              wdata <= merged;
            end
            if (contended) begin
              last_winner_b <= pick_b;
            end
            state <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          wen   <= 1'b0;
          a_gnt <= 1'b0;
          b_gnt <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          wen   <= 1'b0;
          a_gnt <= 1'b0;
          b_gnt <= 1'b0;
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign addr    = DISP_ADDR;
  assign cur_val = shadow;

endmodule

// File: tb/tb_dig8_wr_arbiter.sv
module tb_dig8_wr_arbiter;

  localparam logic [11:0] P_ADDR = 12'h000;
  localparam logic [31:0] P_RV   = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_req = 1'b0;
  logic [7:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_gnt;
  logic        b_req = 1'b0;
  logic [7:0]  b_mask = '0;
  logic [31:0] b_data = '0;
  logic        b_gnt;
  logic        wen;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] cur_val;

  int tests = 0;
  int fails = 0;

  // Reference model: the display's contents and who is owed a turn.
  logic [31:0] m_shadow;
  logic        m_last_b;      // last contended winner was B
  bit          m_fresh;       // reset just released, initial write pending
  bit          m_skip;        // the edge after a grant samples nothing
  logic        e_wen, e_ag, e_bg;
  logic [31:0] e_wdata;
  bit          hold_a = 0;    // keep a_req high across its grant

  dig8_wr_arbiter #(.DISP_ADDR(P_ADDR), .RESET_VAL(P_RV)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_req(a_req), .a_mask(a_mask), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_mask(b_mask), .b_data(b_data), .b_gnt(b_gnt),
    .wen(wen), .addr(addr), .wdata(wdata), .cur_val(cur_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expand(input logic [7:0] m);
    logic [31:0] r = 0;
    for (int i = 0; i < 8; i++) if (m[i]) r = r | (32'hF << (4 * i));
    return r;
  endfunction

  // One clock: update the model from the inputs seen at the edge, then
  // compare every output half a cycle later.
  task automatic cyc(input string tag);
    logic sa, sb, r, win_a;
    logic [7:0] mk;
    logic [31:0] dt, m32;
    @(posedge clk);
    sa = a_req; sb = b_req; r = rst_i;
    e_ag = 0; e_bg = 0; e_wen = 0;
    if (r) begin
      m_shadow = P_RV; e_wdata = P_RV; m_last_b = 1; m_fresh = 1; m_skip = 0;
    end else if (m_fresh) begin
      m_fresh = 0; e_wen = 1; e_wdata = m_shadow;
    end else if (m_skip) begin
      m_skip = 0;
    end else if (sa || sb) begin
      if (sa && sb) begin
        win_a = m_last_b;
        m_last_b = !win_a;
      end else begin
        win_a = sa;
      end
      mk = win_a ? a_mask : b_mask;
      dt = win_a ? a_data : b_data;
      m32 = expand(mk);
      m_shadow = (m_shadow & ~m32) | (dt & m32);
      e_ag = win_a; e_bg = !win_a;
      if (mk != 0) begin e_wen = 1; e_wdata = m_shadow; end
      m_skip = 1;
    end
    @(negedge clk);
    check({tag, ".wen"},   {31'b0, wen},   {31'b0, e_wen});
    check({tag, ".a_gnt"}, {31'b0, a_gnt}, {31'b0, e_ag});
    check({tag, ".b_gnt"}, {31'b0, b_gnt}, {31'b0, e_bg});
    check({tag, ".wdata"}, wdata, e_wdata);
    check({tag, ".cur_val"}, cur_val, m_shadow);
    check({tag, ".addr"}, {20'b0, addr}, {20'b0, P_ADDR});
    // Requesters release req on the edge that ends their grant cycle.
    if (e_ag && !hold_a) a_req = 0;
    if (e_bg) b_req = 0;
  endtask

  initial begin
    // Reset held 3 cycles: no writes, outputs at reset value.
    rst_i = 1;
    repeat (3) cyc("reset");
    rst_i = 0;
    cyc("init_write");
    check("init_wdata_const", wdata, 32'h1234_5678);
    cyc("post_init");

    // Clear shadow, then A alone with low-digit mask.
    a_req = 1; a_mask = 8'hFF; a_data = 32'h0;
    repeat (2) cyc("clear");
    a_req = 1; a_mask = 8'h0F; a_data = 32'hDEAD_BEEF;
    cyc("a_alone");
    check("a_alone_val", cur_val, 32'h0000_BEEF);
    cyc("a_alone_end");

    // Simultaneous pair: A first, then B.
    a_req = 1; a_mask = 8'hF0; a_data = 32'hAAAA_AAAA;
    b_req = 1; b_mask = 8'h0F; b_data = 32'h5555_5555;
    repeat (4) cyc("pair1");
    check("pair1_final", wdata, 32'hAAAA_5555);
    // Further pair: grants alternate.
    a_req = 1; a_mask = 8'h03; a_data = 32'h1111_1111;
    b_req = 1; b_mask = 8'h0C; b_data = 32'h2222_2222;
    repeat (4) cyc("pair2");

    // Zero-mask B request: grant, no write.
    b_req = 1; b_mask = 8'h00; b_data = 32'hFFFF_FFFF;
    repeat (2) cyc("b_zero");

    // Back-to-back A for 6 cycles.
    hold_a = 1;
    a_req = 1; a_mask = 8'h01; a_data = 32'h0000_0003;
    repeat (6) cyc("b2b");
    hold_a = 0; a_req = 0;
    cyc("b2b_end");

    // Reset during the WRITE cycle of a B grant.
    b_req = 1; b_mask = 8'hFF; b_data = 32'hCAFE_F00D;
    cyc("b_grant");
    rst_i = 1;
    cyc("rst_in_write");
    rst_i = 0;
    cyc("rst_init_write");
    repeat (2) cyc("rst_after");

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst_i = ($urandom_range(0, 59) == 0);
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1;
        a_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        a_data = $urandom;
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1;
        b_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        b_data = $urandom;
      end
      cyc("random");
    end
    rst_i = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
